// File: rtl/axi_arb_pkg.sv
// Shared constants and FSM encodings for the SRAM-to-AXI3 arbiter.
package axi_arb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_AR   = 2'd1,
      R_WAIT = 2'd2
   } r_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_SEND = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   localparam logic [ID_W-1:0] ID_INST    = 4'd0;
   localparam logic [ID_W-1:0] ID_DATA    = 4'd1;
   localparam logic [1:0]      BURST_INCR = 2'b01;

   // Single-beat, non-exclusive, non-cacheable, unprivileged accesses only
   localparam logic [3:0] AXI_LEN   = 4'd0;
   localparam logic [1:0] AXI_LOCK  = 2'b00;
   localparam logic [3:0] AXI_CACHE = 4'b0000;
   localparam logic [2:0] AXI_PROT  = 3'b000;
   localparam logic       AXI_WLAST = 1'b1;

   function automatic logic [2:0] to_axi_size(input logic [1:0] size);
      return {1'b0, size};
   endfunction

endpackage

// File: rtl/sram_axi_wr_ctrl.sv
// Write-channel sequencer: issues AW and W independently, then waits for B.
module sram_axi_wr_ctrl
   import axi_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic [STRB_W-1:0] req_strb,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              awready,
   input  logic              wready,
   input  logic              bvalid,
   output logic              awvalid,
   output logic [ADDR_W-1:0] awaddr,
   output logic [2:0]        awsize,
   output logic              wvalid,
   output logic [DATA_W-1:0] wdata,
   output logic [STRB_W-1:0] wstrb,
   output logic              bready,
   output logic              idle_c,
   output logic              done_c
);

   w_state_e state;
   logic     aw_done;
   logic     w_done;
   logic     aw_fire_c;
   logic     w_fire_c;

   assign aw_fire_c = awvalid && awready;
   assign w_fire_c  = wvalid && wready;
   assign idle_c    = (state == W_IDLE);
   assign done_c    = bready && bvalid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= W_IDLE;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         bready  <= 1'b0;
         awaddr  <= '0;
         awsize  <= '0;
         wdata   <= '0;
         wstrb   <= '0;
      end else begin
         case (state)
            W_IDLE: begin
               if (start) begin
                  state   <= W_SEND;
                  awvalid <= 1'b1;
                  wvalid  <= 1'b1;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  awaddr  <= req_addr;
                  awsize  <= to_axi_size(req_size);
                  wdata   <= req_wdata;
                  wstrb   <= req_strb;
               end
            end
            W_SEND: begin
               if (aw_fire_c) begin
                  awvalid <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_fire_c) begin
                  wvalid <= 1'b0;
                  w_done <= 1'b1;
               end
               // Both channels may complete in the same cycle
               if ((aw_done || aw_fire_c) && (w_done || w_fire_c)) begin
                  state  <= W_RESP;
                  bready <= 1'b1;
               end
            end
            W_RESP: begin
               if (bvalid) begin
                  state  <= W_IDLE;
                  bready <= 1'b0;
               end
            end
            default: state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/sram_axi_arbiter.sv
// Shares one AXI3 master between the fetch and data SRAM-like ports.
// Define ARB_ROUND_ROBIN_EN for alternating read grant; default is data-over-fetch priority.
module sram_axi_arbiter
   import axi_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_req,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [STRB_W-1:0] data_wstrb,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic [ID_W-1:0]   arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [3:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic [1:0]        arlock,
   output logic [3:0]        arcache,
   output logic [2:0]        arprot,
   output logic              arvalid,
   input  logic              arready,
   input  logic [ID_W-1:0]   rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic [ID_W-1:0]   awid,
   output logic [ADDR_W-1:0] awaddr,
   output logic [3:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic [1:0]        awlock,
   output logic [3:0]        awcache,
   output logic [2:0]        awprot,
   output logic              awvalid,
   input  logic              awready,
   output logic [ID_W-1:0]   wid,
   output logic [DATA_W-1:0] wdata,
   output logic [STRB_W-1:0] wstrb,
   output logic              wlast,
   output logic              wvalid,
   input  logic              wready,
   input  logic [ID_W-1:0]   bid,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready
);

   r_state_e r_state;
   logic     r_owner_data;
   logic     last_grant_data;
   logic     wr_idle_c;
   logic     wr_done_c;
   logic     data_busy_c;
   logic     data_rd_req_c;
   logic     inst_rd_req_c;
   logic     grant_data_c;
   logic     grant_inst_c;
   logic     store_ok_c;
   logic     r_fire_c;
   logic     unused_ok;

   assign unused_ok = ^{rid, rresp, rlast, bid, bresp, last_grant_data};

   assign arlen   = AXI_LEN;
   assign arburst = BURST_INCR;
   assign arlock  = AXI_LOCK;
   assign arcache = AXI_CACHE;
   assign arprot  = AXI_PROT;
   assign awid    = ID_DATA;
   assign awlen   = AXI_LEN;
   assign awburst = BURST_INCR;
   assign awlock  = AXI_LOCK;
   assign awcache = AXI_CACHE;
   assign awprot  = AXI_PROT;
   assign wid     = ID_DATA;
   assign wlast   = AXI_WLAST;

   // One outstanding data transaction keeps loads and stores ordered
   assign data_busy_c   = ((r_state != R_IDLE) && r_owner_data) || !wr_idle_c;
   assign data_rd_req_c = !reset && data_req && !data_wr && !data_busy_c && (r_state == R_IDLE);
   assign inst_rd_req_c = !reset && inst_req && (r_state == R_IDLE);
   assign store_ok_c    = !reset && data_req && data_wr && !data_busy_c;

`ifdef ARB_ROUND_ROBIN_EN
   assign grant_data_c = data_rd_req_c && (!inst_rd_req_c || !last_grant_data);
   assign grant_inst_c = inst_rd_req_c && (!data_rd_req_c || last_grant_data);
`else
   assign grant_data_c = data_rd_req_c;
   assign grant_inst_c = inst_rd_req_c && !data_rd_req_c;
`endif

   assign inst_addr_ok = grant_inst_c;
   assign data_addr_ok = grant_data_c || store_ok_c;

   assign r_fire_c     = rready && rvalid;
   assign inst_data_ok = r_fire_c && !r_owner_data;
   assign data_data_ok = (r_fire_c && r_owner_data) || wr_done_c;
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

   // Read channel FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= R_IDLE;
         r_owner_data    <= 1'b0;
         last_grant_data <= 1'b0;
         arvalid         <= 1'b0;
         rready          <= 1'b0;
         arid            <= '0;
         araddr          <= '0;
         arsize          <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (grant_data_c || grant_inst_c) begin
                  r_state         <= R_AR;
                  arvalid         <= 1'b1;
                  r_owner_data    <= grant_data_c;
                  last_grant_data <= grant_data_c;
                  arid            <= grant_data_c ? ID_DATA : ID_INST;
                  araddr          <= grant_data_c ? data_addr : inst_addr;
                  arsize          <= to_axi_size(grant_data_c ? data_size : inst_size);
               end
            end
            R_AR: begin
               if (arready) begin
                  r_state <= R_WAIT;
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
               end
            end
            R_WAIT: begin
               if (rvalid) begin
                  r_state <= R_IDLE;
                  rready  <= 1'b0;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   sram_axi_wr_ctrl u_wr_ctrl (
      .clk       (clk),
      .reset     (reset),
      .start     (store_ok_c),
      .req_addr  (data_addr),
      .req_size  (data_size),
      .req_strb  (data_wstrb),
      .req_wdata (data_wdata),
      .awready   (awready),
      .wready    (wready),
      .bvalid    (bvalid),
      .awvalid   (awvalid),
      .awaddr    (awaddr),
      .awsize    (awsize),
      .wvalid    (wvalid),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .bready    (bready),
      .idle_c    (wr_idle_c),
      .done_c    (wr_done_c)
   );

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Scoreboard bench for sram_axi_arbiter: the bench plays the AXI slave cycle by cycle.
module tb_sram_axi_arbiter;
   import axi_arb_pkg::*;

   logic        clk, reset;
   logic        inst_req;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, rid, bid;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [2:0]  arsize, arprot, awsize, awprot;
   logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;

   typedef struct packed {
      logic        st;
      logic [31:0] v;
   } exp_t;

   logic [31:0] inst_q[$];
   exp_t        data_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   sram_axi_arbiter dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      inst_req = 0; inst_size = 2'd2; inst_addr = '0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = '0;
      data_addr = '0; data_wdata = '0;
      arready = 0; rvalid = 0; rdata = '0; rid = '0; rresp = '0; rlast = 1'b1;
      awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;
   endtask

   // AR handshake in the first cycle, R beat in the second
   task automatic serve_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                             input logic [31:0] rd, input bit keep_inst, input bit keep_data);
      tick();
      if (!keep_inst) inst_req = 0;
      if (!keep_data) data_req = 0;
      arready = 1;
      #1;
      check_eq({tag, "_arvalid"}, 32'(arvalid), 32'd1);
      check_eq({tag, "_arid"}, 32'(arid), 32'(id));
      check_eq({tag, "_araddr"}, araddr, addr);
      tick();
      arready = 0; rvalid = 1; rdata = rd;
      #1;
      check_eq({tag, "_rready"}, 32'(rready), 32'd1);
      tick();
      rvalid = 0; rdata = '0;
   endtask

   // Scoreboard: every data_ok pops the oldest expectation of its port
   always @(negedge clk) begin
      #2;
      if (inst_data_ok) begin
         check_eq("inst_sb_pending", 32'(inst_q.size() != 0), 32'd1);
         if (inst_q.size() != 0) check_eq("inst_rdata", inst_rdata, inst_q.pop_front());
      end
      if (data_data_ok) begin
         check_eq("data_sb_pending", 32'(data_q.size() != 0), 32'd1);
         if (data_q.size() != 0) begin
            exp_t e;
            e = data_q.pop_front();
            if (e.st) check_eq("data_store_bready", 32'(bready), 32'd1);
            else      check_eq("data_load_rdata", data_rdata, e.v);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      reset = 1;
      inst_req = 1; data_req = 1;

      // Reset state, addr_ok forced low
      tick(); #1;
      check_eq("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
      check_eq("rst_data_addr_ok", 32'(data_addr_ok), 0);
      check_eq("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 0);
      check_eq("rst_arburst", 32'(arburst), 32'(BURST_INCR));
      check_eq("rst_wlast", 32'(wlast), 1);
      tick();
      reset = 0;
      idle_inputs();

      // Fetch with minimum latency
      tick();
      inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
      #1;
      check_eq("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
      check_eq("t1_data_addr_ok", 32'(data_addr_ok), 0);
      inst_q.push_back(32'h3C1D_0000);
      tick();
      inst_req = 0; arready = 1;
      #1;
      check_eq("t1_arvalid", 32'(arvalid), 1);
      check_eq("t1_arid", 32'(arid), 0);
      check_eq("t1_araddr", araddr, 32'hBFC0_0000);
      check_eq("t1_arsize", 32'(arsize), 2);
      check_eq("t1_dok_early", 32'(inst_data_ok), 0);
      tick();
      arready = 0; rvalid = 1; rdata = 32'h3C1D_0000;
      #1;
      check_eq("t1_inst_data_ok", 32'(inst_data_ok), 1);
      tick();
      rvalid = 0;
      #1;
      check_eq("t1_idle", 32'({arvalid, rready, inst_data_ok}), 0);

      // Tie with last grant = fetch: data wins in both modes
      tick();
      inst_req = 1; inst_addr = 32'hBFC0_0004;
      data_req = 1; data_wr = 0; data_addr = 32'h8000_1004; data_size = 2'd1;
      #1;
      check_eq("t2_data_addr_ok", 32'(data_addr_ok), 1);
      check_eq("t2_inst_addr_ok", 32'(inst_addr_ok), 0);
      data_q.push_back('{st: 1'b0, v: 32'hDEAD_0001});
      serve_read("t2d", ID_DATA, 32'h8000_1004, 32'hDEAD_0001, 1, 0);
      #1;
      check_eq("t2_inst_next_idle", 32'(inst_addr_ok), 1);
      inst_q.push_back(32'h1111_0004);
      serve_read("t2i", ID_INST, 32'hBFC0_0004, 32'h1111_0004, 0, 0);

      // Lone data read sets last grant = data, then a tie
      tick();
      data_req = 1; data_wr = 0; data_addr = 32'h8000_2000;
      #1;
      check_eq("t2b_data_addr_ok", 32'(data_addr_ok), 1);
      data_q.push_back('{st: 1'b0, v: 32'hDEAD_2000});
      serve_read("t2b", ID_DATA, 32'h8000_2000, 32'hDEAD_2000, 0, 0);
      tick();
      inst_req = 1; inst_addr = 32'hBFC0_0008;
      data_req = 1; data_addr = 32'h8000_2004;
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      check_eq("t2c_inst_addr_ok", 32'(inst_addr_ok), 1);
      check_eq("t2c_data_addr_ok", 32'(data_addr_ok), 0);
      inst_q.push_back(32'h3333_0008);
      serve_read("t2ci", ID_INST, 32'hBFC0_0008, 32'h3333_0008, 0, 1);
      #1;
      check_eq("t2c_data_next", 32'(data_addr_ok), 1);
      data_q.push_back('{st: 1'b0, v: 32'hDEAD_2004});
      serve_read("t2cd", ID_DATA, 32'h8000_2004, 32'hDEAD_2004, 0, 0);
`else
      check_eq("t2c_data_addr_ok", 32'(data_addr_ok), 1);
      check_eq("t2c_inst_addr_ok", 32'(inst_addr_ok), 0);
      data_q.push_back('{st: 1'b0, v: 32'hDEAD_2004});
      serve_read("t2cd", ID_DATA, 32'h8000_2004, 32'hDEAD_2004, 1, 0);
      #1;
      check_eq("t2c_inst_next", 32'(inst_addr_ok), 1);
      inst_q.push_back(32'h3333_0008);
      serve_read("t2ci", ID_INST, 32'hBFC0_0008, 32'h3333_0008, 0, 0);
`endif

      // Store with W handshake delayed past AW
      tick();
      data_req = 1; data_wr = 1; data_addr = 32'h8000_3000; data_size = 2'd1;
      data_wstrb = 4'b0011; data_wdata = 32'h1234_ABCD;
      #1;
      check_eq("t3_addr_ok", 32'(data_addr_ok), 1);
      data_q.push_back('{st: 1'b1, v: 32'h0});
      tick();
      data_req = 0; data_wr = 0; awready = 1;
      #1;
      check_eq("t3_c1_valids", 32'({awvalid, wvalid, bready}), 32'b110);
      check_eq("t3_awaddr", awaddr, 32'h8000_3000);
      check_eq("t3_awsize", 32'(awsize), 1);
      check_eq("t3_wdata", wdata, 32'h1234_ABCD);
      check_eq("t3_wstrb", 32'(wstrb), 32'b0011);
      check_eq("t3_awid", 32'(awid), 32'(ID_DATA));
      tick();
      awready = 0;
      #1;
      check_eq("t3_c2_valids", 32'({awvalid, wvalid, bready}), 32'b010);
      tick();
      wready = 1;
      #1;
      check_eq("t3_c3_valids", 32'({awvalid, wvalid, bready}), 32'b010);
      tick();
      wready = 0;
      #1;
      check_eq("t3_c4_valids", 32'({awvalid, wvalid, bready}), 32'b001);
      check_eq("t3_c4_dok", 32'(data_data_ok), 0);
      tick();
      bvalid = 1;
      #1;
      check_eq("t3_dok", 32'(data_data_ok), 1);
      tick();
      bvalid = 0;
      #1;
      check_eq("t3_bready_off", 32'(bready), 0);

      // Load blocked behind a store while a fetch completes
      tick();
      data_req = 1; data_wr = 1; data_addr = 32'h8000_4000; data_wstrb = 4'hF;
      data_wdata = 32'hCAFE_F00D; awready = 1; wready = 1;
      #1;
      check_eq("t4_store_ok", 32'(data_addr_ok), 1);
      data_q.push_back('{st: 1'b1, v: 32'h0});
      tick();
      data_wr = 0; inst_req = 1; inst_addr = 32'hBFC0_0010;
      #1;
      check_eq("t4_c1_load_blocked", 32'(data_addr_ok), 0);
      check_eq("t4_c1_inst_ok", 32'(inst_addr_ok), 1);
      inst_q.push_back(32'h2222_0010);
      tick();
      awready = 0; wready = 0; inst_req = 0; arready = 1;
      #1;
      check_eq("t4_c2_load_blocked", 32'(data_addr_ok), 0);
      check_eq("t4_c2_arid", 32'(arid), 0);
      check_eq("t4_c2_bready", 32'(bready), 1);
      tick();
      arready = 0; rvalid = 1; rdata = 32'h2222_0010;
      #1;
      check_eq("t4_c3_load_blocked", 32'(data_addr_ok), 0);
      check_eq("t4_c3_inst_dok", 32'(inst_data_ok), 1);
      tick();
      rvalid = 0; bvalid = 1;
      #1;
      check_eq("t4_c4_load_blocked", 32'(data_addr_ok), 0);
      check_eq("t4_c4_dok", 32'(data_data_ok), 1);
      tick();
      bvalid = 0;
      #1;
      check_eq("t4_c5_load_ok", 32'(data_addr_ok), 1);
      data_q.push_back('{st: 1'b0, v: 32'h55AA_0000});
      serve_read("t4l", ID_DATA, 32'h8000_4000, 32'h55AA_0000, 0, 0);

      // Reset while the read waits for R and a store is in flight
      tick();
      inst_req = 1; inst_addr = 32'hBFC0_0020;
      data_req = 1; data_wr = 1; data_addr = 32'h8000_5000;
      #1;
      check_eq("t5_inst_ok", 32'(inst_addr_ok), 1);
      check_eq("t5_store_ok", 32'(data_addr_ok), 1);
      tick();
      inst_req = 0; data_req = 0; data_wr = 0; arready = 1;
      #1;
      check_eq("t5_awvalid", 32'(awvalid), 1);
      tick();
      arready = 0; reset = 1;
      #1;
      check_eq("t5_rwait", 32'(rready), 1);
      tick();
      rvalid = 1; inst_req = 1;
      #1;
      check_eq("t5_rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 0);
      check_eq("t5_rst_oks", 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 0);
      tick();
      reset = 0;
      idle_inputs();

      // Recovery fetch after reset
      tick();
      inst_req = 1; inst_addr = 32'hBFC0_0030;
      #1;
      check_eq("t6_inst_ok", 32'(inst_addr_ok), 1);
      inst_q.push_back(32'h7777_0030);
      serve_read("t6", ID_INST, 32'hBFC0_0030, 32'h7777_0030, 0, 0);
      tick();
      tick();

      check_eq("inst_q_drained", 32'(inst_q.size()), 0);
      check_eq("data_q_drained", 32'(data_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
